// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed; the unused code 2'd3 behaves as IDLE.
package serial_subtractor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam int DEF_WIDTH = 4;

  // Anything that is not SHIFT or DONE is treated as IDLE.
  function automatic logic st_is_idle(input state_t s);
    return !((s == ST_SHIFT) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin.
// Purely combinational; the serial datapath reuses it every cycle.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic axb;

  assign axb    = a_i ^ b_i;
  assign d_o    = axb ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~axb & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor with start/ready/done handshake.
// The minuend register doubles as the result shift register.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic st_idle;
  logic st_shift;
  logic st_done;

  logic cell_d;
  logic cell_bout;

  assign st_shift = (state_q == ST_SHIFT);
  assign st_done  = (state_q == ST_DONE);
  assign st_idle  = st_is_idle(state_q);

  full_subtractor u_fs (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand shifters, borrow, counter, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  // Next-state and datapath update: capture, shift one bit, finish
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (1'b1)
      st_idle: begin
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      st_shift: begin
        a_d   = {cell_d, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = cell_bout;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          diff_d  = {cell_d, a_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      st_done: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready = st_idle;
  assign busy  = st_shift;
  assign done  = st_done;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4).
// Outputs sampled on the falling edge; inputs driven there too.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op from a falling edge in IDLE; return at the falling
  // edge where done is first seen (or when the bound expires).
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic bi_n, output logic [W-1:0] d_obs,
                        output logic bo_obs, output int lat);
    a = ai;
    b = bi;
    bin = bi_n;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ai;
    b = ~bi;
    bin = ~bi_n;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    d_obs = diff;
    bo_obs = bout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (diff !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_diff got %b want 0000", diff);
    end
    vectors++;
    if (bout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bout got %b want 0", bout);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got %b want 0", done);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 1", ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic         cv [4];
    logic [W-1:0] dv [4];
    logic         ov [4];
    logic [W-1:0] d_obs;
    logic         bo_obs;
    int           lat;
    av = '{4'b0011, 4'b0000, 4'b1010, 4'b0101};
    bv = '{4'b0001, 4'b0001, 4'b0101, 4'b0101};
    cv = '{1'b0, 1'b0, 1'b1, 1'b1};
    dv = '{4'b0010, 4'b1111, 4'b0100, 4'b1111};
    ov = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], cv[i], d_obs, bo_obs, lat);
      vectors++;
      if (lat !== W) begin
        miscompares++;
        $display("FAIL basic%0d_latency got %0d want %0d", i, lat, W);
      end
      vectors++;
      if (d_obs !== dv[i]) begin
        miscompares++;
        $display("FAIL basic%0d_diff got %b want %b", i, d_obs, dv[i]);
      end
      vectors++;
      if (bo_obs !== ov[i]) begin
        miscompares++;
        $display("FAIL basic%0d_bout got %b want %b", i, bo_obs, ov[i]);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL basic%0d_idle done=%b ready=%b want 0/1",
                 i, done, ready);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int pulses;
    a = 4'b1001;
    b = 4'b0011;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
    pulses = 0;
    for (int c = 1; c <= W + 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (c == 2) begin
        vectors++;
        if (diff !== 4'b1111) begin
          miscompares++;
          $display("FAIL busy_hold_prev got %b want 1111", diff);
        end
        start = 1'b1;
        a = 4'b1111;
        b = 4'b0000;
      end else begin
        start = 1'b0;
      end
      if (c < W) begin
        vectors++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_flags c=%0d ready=%b busy=%b want 0/1",
                   c, ready, busy);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL busy_done_pulses got %0d want 1", pulses);
    end
    vectors++;
    if (diff !== 4'b0110 || bout !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_result got %b/%b want 0110/0", diff, bout);
    end
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_end_idle ready=%b busy=%b want 1/0", ready, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] d_obs;
    logic         bo_obs;
    int           lat;
    int           pulses;
    a = 4'b0111;
    b = 4'b0010;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (diff !== 4'b0000 || bout !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_result got %b/%b want 0000/0", diff, bout);
    end
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_flags done=%b ready=%b busy=%b want 0/1/0",
               done, ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_done got %0d pulses want 0", pulses);
    end
    run_op(4'b0111, 4'b0010, 1'b0, d_obs, bo_obs, lat);
    vectors++;
    if (lat !== W || d_obs !== 4'b0101 || bo_obs !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_fresh lat=%0d res=%b/%b want %0d 0101/0",
               lat, d_obs, bo_obs, W);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W:0] expv;
    start = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          vectors++;
          if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready a=%0d b=%0d bin=%0d got %b want 1",
                     ai, bi, ci, ready);
          end
          a = W'(ai);
          b = W'(bi);
          bin = ci[0];
          expv = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
          @(posedge clk);
          @(negedge clk);
          a = W'($urandom);
          b = W'($urandom);
          bin = 1'($urandom);
          for (int c = 1; c <= W; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < W) begin
              vectors++;
              if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_early_done c=%0d got %b want 0", c, done);
              end
            end else begin
              vectors++;
              if (done !== 1'b1 || {bout, diff} !== expv) begin
                miscompares++;
                $display("FAIL b2b_result a=%0d b=%0d bin=%0d got %b/%b%b want 1/%b",
                         ai, bi, ci, done, bout, diff, expv);
                $fatal(1, "b2b result mismatch");
              end
            end
          end
          @(posedge clk);
          @(negedge clk);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_reset_mid_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
